alu_unit: RTL and testbench

32-bit integer ALU for the EX stage of the pipelined RV32I core. Computes logic, add/sub, shift and set-less-than results selected by a 4-bit Operation code. Provides a combinational result for same-cycle forwarding. Also provides a registered copy with a valid flag for the EX/MEM boundary.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_shifter.sv | 23 ++
 rtl/alu_unit.sv | 134 +++++++++++++
 tb/tb_alu_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the EX-stage ALU.
package alu_pkg;

    localparam int ALU_SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SUB  = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SLT  = 4'b1001,
        ALU_SLTU = 4'b1010,
        ALU_SRA  = 4'b1011
    } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA; other ops yield 0.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]       a,
    input  logic [ALU_SHAMT_W-1:0] shamt,
    input  alu_op_e                op,
    output logic [WIDTH-1:0]       y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SRA: y = $unsigned($signed(a) >>> shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// RV32I EX-stage ALU: combinational result for forwarding plus a registered
// EX/MEM copy. Optional flag outputs are built when ALU_FLAGS_EN is defined.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       Operation,
    input  logic             in_valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [WIDTH-1:0] ALUResult_q,
    output logic             Zero_q,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             Carry_q,
    output logic             Overflow_q,
    output logic             Negative_q
`endif
);

    alu_op_e          op;
    logic [WIDTH-1:0] shift_res;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic             out_valid_q;

    assign op = alu_op_e'(Operation);

    alu_shifter #(.WIDTH(WIDTH)) u_shifter (
        .a     (SrcA),
        .shamt (SrcB[ALU_SHAMT_W-1:0]),
        .op    (op),
        .y     (shift_res)
    );

`ifdef ALU_FLAGS_EN
    // One extra bit on add/sub exposes carry-out and borrow.
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic           carry_d;
    logic           overflow_d;
    logic           negative_d;

    assign add_w = {1'b0, SrcA} + {1'b0, SrcB};
    assign sub_w = {1'b0, SrcA} - {1'b0, SrcB};
`else
    logic [WIDTH-1:0] add_w;
    logic [WIDTH-1:0] sub_w;

    assign add_w = SrcA + SrcB;
    assign sub_w = SrcA - SrcB;
`endif

    always_comb begin
        result_d = '0;
        case (op)
            ALU_AND:  result_d = SrcA & SrcB;
            ALU_OR:   result_d = SrcA | SrcB;
            ALU_XOR:  result_d = SrcA ^ SrcB;
            ALU_ADD:  result_d = add_w[WIDTH-1:0];
            ALU_SUB:  result_d = sub_w[WIDTH-1:0];
            ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
            ALU_SLL, ALU_SRL, ALU_SRA: result_d = shift_res;
            default:  result_d = '0;
        endcase
        zero_d = (result_d == '0);
    end

    assign ALUResult = result_d;
    assign Zero      = zero_d;
    assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
    always_comb begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        negative_d = result_d[WIDTH-1];
        case (op)
            ALU_ADD: begin
                carry_d    = add_w[WIDTH];
                overflow_d = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) &&
                             (result_d[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ALU_SUB: begin
                // Carry on SUB means no borrow, i.e. A >= B unsigned.
                carry_d    = ~sub_w[WIDTH];
                overflow_d = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) &&
                             (result_d[WIDTH-1] != SrcA[WIDTH-1]);
            end
            default: ;
        endcase
    end

    assign Carry    = carry_d;
    assign Overflow = overflow_d;
    assign Negative = negative_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Carry_q    <= 1'b0;
            Overflow_q <= 1'b0;
            Negative_q <= 1'b0;
        end else begin
            Carry_q    <= carry_d;
            Overflow_q <= overflow_d;
            Negative_q <= negative_d;
        end
    end
`endif

    // Capture every cycle; downstream qualifies with out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ALUResult_q <= '0;
            Zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            ALUResult_q <= result_d;
            Zero_q      <= zero_d;
            out_valid_q <= in_valid;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, random ops, scoreboarded
// registered stage and asynchronous reset. Define ALU_FLAGS_EN to test flags.
module tb_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic        in_valid;
    logic [31:0] ALUResult, ALUResult_q;
    logic        Zero, Zero_q, out_valid;
`ifdef ALU_FLAGS_EN
    logic Carry, Overflow, Negative, Carry_q, Overflow_q, Negative_q;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        logic        v;
    } exp_t;
    exp_t sb[$];

    alu_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .Operation   (Operation),
        .in_valid    (in_valid),
        .ALUResult   (ALUResult),
        .Zero        (Zero),
        .ALUResult_q (ALUResult_q),
        .Zero_q      (Zero_q),
        .out_valid   (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .Carry       (Carry),
        .Overflow    (Overflow),
        .Negative    (Negative),
        .Carry_q     (Carry_q),
        .Overflow_q  (Overflow_q),
        .Negative_q  (Negative_q)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a ^ b;
            4'b0110: return a - b;
            4'b0111: return a << sh;
            4'b1000: return a >> sh;
            4'b1001: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1010: return (a < b) ? 32'd1 : 32'd0;
            4'b1011: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Drive on negedge, check combinational result, then check registered copy
    // popped from the scoreboard after the following rising edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic v, input logic [31:0] er, input string tag);
        exp_t e;
        @(negedge clk);
        SrcA = a; SrcB = b; Operation = op; in_valid = v;
        #1;
        chk(tag, ALUResult, er);
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, er == 32'd0});
        sb.push_back('{r: er, z: (er == 32'd0), v: v});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q"}, ALUResult_q, e.r);
            chk({tag, "_zero_q"}, {31'd0, Zero_q}, {31'd0, e.z});
            chk({tag, "_vld_q"}, {31'd0, out_valid}, {31'd0, e.v});
        end
    endtask

    initial begin
        logic [3:0]  ops [10];
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
                4'b0111, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        SrcA = '0; SrcB = '0; Operation = '0; in_valid = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_result_q", ALUResult_q, 32'd0);
        chk("rst_zero_q", {31'd0, Zero_q}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        step(32'h113C2DE4, 32'hFB0B4877, 4'b0000, 1'b1, 32'h11080864, "and");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b0001, 1'b1, 32'hFB3F6DF7, "or");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b0011, 1'b0, 32'hEA376593, "xor");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b0010, 1'b1, 32'h0C47765B, "add");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b0110, 1'b1, 32'h1630E56D, "sub");
        step(32'h113C2DE4, 32'h0000000A, 4'b1000, 1'b1, 32'h00044F0B, "srl");
        step(32'h113C2DE4, 32'h0000000A, 4'b0111, 1'b1, 32'hF0B79000, "sll");
        step(32'h113C2DE4, 32'h0000000A, 4'b1001, 1'b1, 32'h00000000, "slt_pos");
        step(32'h113C2DE4, 32'h0000000A, 4'b1010, 1'b1, 32'h00000000, "sltu_pos");
        step(32'hFB0B4877, 32'h0000000A, 4'b1011, 1'b1, 32'hFFFEC2D2, "sra");
        step(32'hFB0B4877, 32'h0000000A, 4'b1001, 1'b1, 32'h00000001, "slt_neg");
        step(32'hFB0B4877, 32'h0000000A, 4'b1010, 1'b1, 32'h00000000, "sltu_neg");
        step(32'hFB0B4877, 32'h0000002A, 4'b1011, 1'b1, 32'hFFFEC2D2, "sra_hi_b");
        step(32'h113C2DE4, 32'h00000020, 4'b0111, 1'b1, 32'h113C2DE4, "sll_by_32");
        step(32'h00000005, 32'h00000005, 4'b0110, 1'b1, 32'h00000000, "sub_zero");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b1111, 1'b1, 32'h00000000, "op_1111");
        step(32'h113C2DE4, 32'hFB0B4877, 4'b0100, 1'b0, 32'h00000000, "op_0100");
        step(32'hFFFFFFFF, 32'h00000001, 4'b0010, 1'b1, 32'h00000000, "add_wrap");

        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = ops[$urandom_range(0, 9)];
            step(ra, rb, rop, 1'($urandom_range(0, 1)), ref_alu(ra, rb, rop), "rand");
        end

        // Mid-stream asynchronous reset, checked between clock edges.
        step(32'd1, 32'd2, 4'b0010, 1'b1, 32'd3, "reg_add");
        #2 reset = 1'b0;
        #1;
        chk("async_rst_q", ALUResult_q, 32'd0);
        chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("async_rst_comb", ALUResult, 32'd3);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        step(32'd7, 32'd9, 4'b0110, 1'b1, 32'hFFFFFFFE, "post_rst");

`ifdef ALU_FLAGS_EN
        @(negedge clk);
        SrcA = 32'h7FFFFFFF; SrcB = 32'd1; Operation = 4'b0010; in_valid = 1'b1;
        #1;
        chk("ovf_overflow", {31'd0, Overflow}, 32'd1);
        chk("ovf_negative", {31'd0, Negative}, 32'd1);
        chk("ovf_carry", {31'd0, Carry}, 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_overflow_q", {31'd0, Overflow_q}, 32'd1);
        chk("ovf_negative_q", {31'd0, Negative_q}, 32'd1);
        @(negedge clk);
        SrcA = 32'hFFFFFFFF; SrcB = 32'd1; Operation = 4'b0010;
        #1;
        chk("cy_carry", {31'd0, Carry}, 32'd1);
        chk("cy_zero", {31'd0, Zero}, 32'd1);
        chk("cy_overflow", {31'd0, Overflow}, 32'd0);
        @(posedge clk);
        #1;
        chk("cy_carry_q", {31'd0, Carry_q}, 32'd1);
        @(negedge clk);
        SrcA = 32'd3; SrcB = 32'd5; Operation = 4'b0110;
        #1;
        chk("sub_borrow_carry", {31'd0, Carry}, 32'd0);
        chk("sub_borrow_neg", {31'd0, Negative}, 32'd1);
        @(negedge clk);
        SrcA = 32'hFFFFFFFF; SrcB = 32'hFFFFFFFF; Operation = 4'b0000;
        #1;
        chk("and_carry", {31'd0, Carry}, 32'd0);
        chk("and_negative", {31'd0, Negative}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
